// File: rtl/timer_pkg.sv
// timer_pkg: shared state encoding, BCD digit layout and load validation for the cook timer
package timer_pkg;
  localparam int DIGIT_W = 4;
  localparam int NUM_DIGITS = 4;
  localparam int TIME_W = DIGIT_W * NUM_DIGITS;
  localparam int SEC_ONES = 0;
  localparam int SEC_TENS = 1;
  localparam int MIN_ONES = 2;
  localparam int MIN_TENS = 3;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PAUSED, ST_DONE} state_e;
  function automatic logic bcd_ok(input logic [TIME_W-1:0] t, input logic [DIGIT_W-1:0] tens_max);
    bcd_ok = t[SEC_TENS*DIGIT_W +: DIGIT_W] <= tens_max;
    for (int i = 0; i < NUM_DIGITS; i++) bcd_ok = bcd_ok & (t[i*DIGIT_W +: DIGIT_W] <= DIGIT_W'(9));
  endfunction
endpackage

// File: rtl/bcd_digit_down.sv
// bcd_digit_down: one BCD down-counting digit that wraps 0 to MAX and borrows from the next digit
module bcd_digit_down
  import timer_pkg::*;
#(
  parameter int MAX = 9
) (
  input  logic               dec_en_i,
  input  logic [DIGIT_W-1:0] digit_i,
  output logic [DIGIT_W-1:0] digit_o,
  output logic               borrow_o
);
  assign borrow_o = dec_en_i & (digit_i == '0);
  assign digit_o  = !dec_en_i ? digit_i : (digit_i == '0) ? DIGIT_W'(MAX) : digit_i - 1'b1;
endmodule

// File: rtl/countdown_timer_bcd.sv
// countdown_timer_bcd: MM:SS BCD cook timer driven by the 1 Hz tick, with done pulse and beep window
module countdown_timer_bcd
  import timer_pkg::*;
#(
  parameter int BEEP_SECONDS = 3,
  parameter int SEC_TENS_MAX = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick_in_i,
  input  logic              load_i,
  input  logic [TIME_W-1:0] time_in_i,
  input  logic              start_i,
  input  logic              pause_i,
  input  logic              clear_i,
  output logic [TIME_W-1:0] time_out_o,
  output logic              running_o,
  output logic              done_o,
  output logic              beep_o,
  output logic              load_err_o
);
  state_e state_q, state_d;
  logic [TIME_W-1:0] time_q, time_d, time_dec;
  logic [3:0] cnt_q, cnt_d;
  logic tick_q, done_q, done_d, err_q, err_d;
  logic tick_rise, load_act, valid, dec;
  logic [NUM_DIGITS:0] borrow;
  assign tick_rise = tick_in_i & ~tick_q;
  assign load_act  = ~clear_i & load_i & (state_q != ST_RUN);
  assign valid     = bcd_ok(time_in_i, DIGIT_W'(SEC_TENS_MAX));
  assign dec       = (state_q == ST_RUN) & tick_rise & ~clear_i & ~pause_i;
  assign borrow[0] = dec;
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    bcd_digit_down #(.MAX(g == SEC_TENS ? SEC_TENS_MAX : 9)) u_digit (
      .dec_en_i(borrow[g]),
      .digit_i (time_q[g*DIGIT_W +: DIGIT_W]),
      .digit_o (time_dec[g*DIGIT_W +: DIGIT_W]),
      .borrow_o(borrow[g+1])
    );
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      time_q  <= '0;
      cnt_q   <= '0;
      tick_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      time_q  <= time_d;
      cnt_q   <= cnt_d;
      tick_q  <= tick_in_i;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end
  always_comb begin
    state_d = clear_i ? ST_IDLE
            : load_act ? ((valid && state_q == ST_DONE) ? ST_IDLE : state_q)
            : (pause_i && state_q == ST_RUN) ? ST_PAUSED
            : (start_i && (state_q == ST_IDLE || state_q == ST_PAUSED) && time_q != '0) ? ST_RUN
            : done_d ? ST_DONE
            : state_q;
  end
  // a borrow out of the minutes-tens digit would mean underflow; 00:00 is caught before that
  always_comb begin
    done_d = dec & (time_q == TIME_W'(16'h0001));
    err_d  = load_act & ~valid;
    time_d = clear_i ? '0 : (load_act & valid) ? time_in_i : (dec & ~borrow[NUM_DIGITS]) ? time_dec : time_q;
    cnt_d  = (clear_i | (load_act & valid)) ? '0
           : done_d ? 4'(BEEP_SECONDS)
           : (state_q == ST_DONE && tick_rise && cnt_q != '0) ? cnt_q - 1'b1
           : cnt_q;
  end
  assign time_out_o = time_q;
  assign running_o  = (state_q == ST_RUN);
  assign done_o     = done_q;
  assign beep_o     = (cnt_q != '0);
  assign load_err_o = err_q;
endmodule

// File: tb/tb_countdown_timer_bcd.sv
// tb_countdown_timer_bcd: directed vectors with hand-computed expectations for the cook timer
module tb_countdown_timer_bcd;
  logic clk = 1'b0, rst_n = 1'b0, tick_in = 1'b0, load = 1'b0, start = 1'b0, pause = 1'b0, clear = 1'b0;
  logic [15:0] time_in = '0, time_out;
  logic running, done, beep, load_err;
  logic [15:0] snap_t;
  logic snap_done, snap_beep, snap_run;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  countdown_timer_bcd #(.BEEP_SECONDS(3), .SEC_TENS_MAX(5)) dut (
    .clk(clk), .rst_n(rst_n), .tick_in_i(tick_in), .load_i(load), .time_in_i(time_in),
    .start_i(start), .pause_i(pause), .clear_i(clear), .time_out_o(time_out),
    .running_o(running), .done_o(done), .beep_o(beep), .load_err_o(load_err)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic do_load(input logic [15:0] v);
    @(negedge clk);
    time_in = v;
    load = 1'b1;
    step();
    load = 1'b0;
  endtask
  task automatic do_start;
    @(negedge clk);
    start = 1'b1;
    step();
    start = 1'b0;
  endtask
  task automatic do_pause;
    @(negedge clk);
    pause = 1'b1;
    step();
    pause = 1'b0;
  endtask
  task automatic do_clear;
    @(negedge clk);
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask
  task automatic tick;
    @(negedge clk);
    tick_in = 1'b1;
    step();
    snap_t = time_out;
    snap_done = done;
    snap_beep = beep;
    snap_run = running;
    @(negedge clk);
    tick_in = 1'b0;
    repeat (3) step();
  endtask
  initial begin
    repeat (3) step();
    check("reset_outputs", {time_out, running, done, beep, load_err}, 20'h0);
    @(negedge clk);
    rst_n = 1'b1;
    do_load(16'h0003);
    check("t1_load", time_out, 16'h0003);
    do_start();
    check("t1_running", running, 1);
    tick();
    check("t1_tick1", snap_t, 16'h0002);
    tick();
    check("t1_tick2", {snap_t, snap_done}, {16'h0001, 1'b0});
    tick();
    check("t1_tick3", {snap_t, snap_done, snap_beep, snap_run}, {16'h0000, 1'b1, 1'b1, 1'b0});
    check("t1_done_one_cycle", done, 0);
    tick();
    check("t1_beep1", {snap_beep, snap_done}, {1'b1, 1'b0});
    tick();
    check("t1_beep2", snap_beep, 1);
    tick();
    check("t1_beep3_off", snap_beep, 0);
    do_start();
    check("t1_start_in_done", running, 0);
    do_load(16'h1000);
    do_start();
    tick();
    check("t2_min_borrow", snap_t, 16'h0959);
    @(negedge clk);
    tick_in = 1'b1;
    repeat (50) step();
    check("t2_held_level", time_out, 16'h0958);
    @(negedge clk);
    tick_in = 1'b0;
    step();
    do_clear();
    check("t3_clear", {time_out, running}, {16'h0000, 1'b0});
    do_load(16'h0100);
    do_start();
    tick();
    check("t3_tick", {snap_t, snap_run}, {16'h0059, 1'b1});
    do_pause();
    check("t3_paused", running, 0);
    tick();
    tick();
    check("t3_ticks_paused", snap_t, 16'h0059);
    do_start();
    check("t3_resume", running, 1);
    tick();
    check("t3_tick_resumed", snap_t, 16'h0058);
    @(negedge clk);
    pause = 1'b1;
    tick_in = 1'b1;
    step();
    pause = 1'b0;
    check("t3_pause_with_tick", {time_out, running}, {16'h0058, 1'b0});
    @(negedge clk);
    tick_in = 1'b0;
    step();
    do_clear();
    do_load(16'h0075);
    check("t4_bad_sec_tens", {time_out, load_err}, {16'h0000, 1'b1});
    step();
    check("t4_err_one_cycle", load_err, 0);
    do_load(16'h00A0);
    check("t4_bad_digit", {time_out, load_err}, {16'h0000, 1'b1});
    do_load(16'h0A00);
    check("t4_bad_min_ones", load_err, 1);
    do_load(16'h0059);
    check("t4_good_load", {time_out, load_err}, {16'h0059, 1'b0});
    do_clear();
    do_load(16'h0010);
    @(negedge clk);
    start = 1'b1;
    tick_in = 1'b1;
    step();
    start = 1'b0;
    check("t5_start_with_tick", {time_out, running}, {16'h0010, 1'b1});
    @(negedge clk);
    tick_in = 1'b0;
    step();
    tick();
    check("t5_sec_borrow", snap_t, 16'h0009);
    do_clear();
    do_load(16'h0230);
    do_start();
    do_load(16'h0500);
    check("t5_load_in_run", {time_out, running, load_err}, {16'h0230, 1'b1, 1'b0});
    @(negedge clk);
    clear = 1'b1;
    tick_in = 1'b1;
    step();
    clear = 1'b0;
    check("t5_clear_with_tick", {time_out, running, done}, {16'h0000, 1'b0, 1'b0});
    @(negedge clk);
    tick_in = 1'b0;
    step();
    do_start();
    check("t5_start_at_zero", running, 0);
    do_load(16'h0045);
    do_start();
    check("t6_running", {time_out, running}, {16'h0045, 1'b1});
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("t6_async_reset", {time_out, running, done, beep, load_err}, 20'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("t6_tick_after_reset", {snap_t, snap_done, snap_run}, {16'h0000, 1'b0, 1'b0});
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/countdown_timer_bcd.md
Name: countdown_timer_bcd

Overview:
- Microwave cook-time countdown, directly downstream of the 1 Hz divider; consumes its `out` signal as `tick_in`.
- Holds a 4-digit BCD time MM:SS loaded from the timer-entry logic and decrements it by one second per tick rising edge.
- Drives the display digits, a `running` flag, a one-cycle `done` pulse and an end-of-cook beep window.

Parameters:
- BEEP_SECONDS, 3, number of tick rising edges `beep` stays high after reaching 00:00 (range 1..15)
- SEC_TENS_MAX, 5, maximum legal seconds-tens digit

Ports:
- clk  in  1  system clock, same 100 Hz domain as the 1 Hz divider
- rst_n  in  1  asynchronous active-low reset
- tick_in  in  1  divider output, synchronous to clk; only its rising edge counts
- load  in  1  load `time_in` into the counter (single-cycle strobe)
- time_in  in  16  BCD {min_tens, min_ones, sec_tens, sec_ones}, 4 bits each
- start  in  1  begin or resume countdown
- pause  in  1  suspend countdown (door open / pause key)
- clear  in  1  abort, zero time, return to IDLE
- time_out  out  16  current BCD time, same packing as `time_in`
- running  out  1  high in RUN state
- done  out  1  one-cycle pulse on reaching 00:00
- beep  out  1  high for BEEP_SECONDS ticks after done
- load_err  out  1  one-cycle pulse when a load is rejected

Behaviour:
- Reset (async, rst_n=0): state=IDLE, time_out=16'h0000, tick_q=0, beep counter=0, all 1-bit outputs 0.
- Edge detect: tick_q<=tick_in each clk; `tick_rise = tick_in & ~tick_q`. A level held high counts once.
- States: IDLE, RUN, PAUSED, DONE.
- Command priority, highest first: clear > load > pause > start.
- clear (any state): time_out<=0, state<=IDLE, beep<=0. No done pulse.
- load:
  - Accepted only in IDLE, PAUSED or DONE.
  - Every digit must be <=9 and sec_tens must be <=SEC_TENS_MAX; otherwise load_err=1 next cycle and time unchanged.
  - A valid load updates time_out next cycle. From DONE it goes to IDLE and drops beep.
  - load in RUN is ignored; no error pulse.
- start:
  - IDLE/PAUSED to RUN if time_out != 0.
  - start with time 0 is ignored.
  - start in RUN or DONE is ignored.
- pause: RUN to PAUSED; ignored elsewhere. A tick_rise in the same cycle as pause is discarded.
- RUN decrement: on tick_rise, time_out updates the next clk edge (latency 1 from tick_rise).
  - sec_ones: 0 wraps to 9 with borrow.
  - sec_tens: 0 wraps to SEC_TENS_MAX with borrow.
  - min_ones: 0 wraps to 9 with borrow.
  - min_tens: decrements on borrow; never underflows because 00:00 is caught first.
  - Example: 10:00 to 09:59; 01:00 to 00:59.
- Completion: when time_out==00:01 and tick_rise occurs in RUN:
  - time_out<=0, state<=DONE, done=1 for exactly that following cycle.
  - beep<=1 and beep counter<=BEEP_SECONDS.
- DONE: each tick_rise decrements the beep counter; beep drops the cycle the counter reaches 0. The state stays DONE until clear or load.
- Simultaneous events: clear+tick_rise, clear wins; start+tick_rise in IDLE, enter RUN with no decrement in that cycle.
- Reset mid-RUN forces the reset values immediately; no done pulse.
- running = (state==RUN), registered.

Decomposition:
- Package `timer_pkg`:
  - state encoding constants ST_IDLE, ST_RUN, ST_PAUSED, ST_DONE (2 bits)
  - BCD digit width constant (4)
  - the time_in/time_out digit index localparams
- Sub-module `bcd_digit_down`: one digit, parameter MAX, inputs dec_en/digit, outputs next digit and borrow_out. Instantiated 4×: MAX 9, SEC_TENS_MAX, 9, 9.

Test Plan:
1. Load 16'h0003, start, three tick_in rising edges 1 s apart -> time_out 0002, 0001, 0000; done high exactly one clk after the third edge; beep high for 3 further tick edges, then 0; state DONE.
2. Load 16'h1000, start, one tick -> time_out=16'h0959; tick held high for 50 clk -> only one decrement.
3. Load 16'h0100, start, tick, pause, two ticks, start, tick -> 0059, 0059, 0059, 0058; running 1,0,1.
4. Load 16'h0075 -> load_err pulse, time_out unchanged; load 16'h00A0 -> load_err; load 16'h0059 -> accepted, no err.
5. In RUN at 16'h0230, assert load 16'h0500 -> ignored; clear and tick in the same cycle -> time_out=0000, IDLE, no done; start at 0000 -> stays IDLE.
6. Drop rst_n mid-RUN at 16'h0045 -> all outputs 0 asynchronously; after release, a tick causes no change.
